cpu_multicycle: RTL



---
 rtl/cpu_multicycle_if.sv | 27 ++
 rtl/cpu_multicycle.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cpu_multicycle_if.sv
// Instruction and data memory req/ack bus of the multicycle core.
// The core drives requests through the master modport; memories use slave.
interface cpu_multicycle_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [15:0]       imem_rdata;
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ack;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/cpu_multicycle.sv
// 4-register load/store CPU executing a 16-bit ISA through a
// FETCH/DECODE/EXEC/MEM/WB state machine with req/ack memories.
module cpu_multicycle #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    cpu_multicycle_if.master  bus,
    output logic              halted,
    output logic [ADDR_W-1:0] debug_pc,
    output logic [DATA_W-1:0] debug_alu_result,
    output logic [2:0]        debug_state
);
    typedef enum logic [2:0] {
        StInit   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } state_e;

    localparam logic [3:0] OpLdi = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpAnd = 4'h4;
    localparam logic [3:0] OpOr  = 4'h5;
    localparam logic [3:0] OpXor = 4'h6;
    localparam logic [3:0] OpNot = 4'h7;
    localparam logic [3:0] OpShl = 4'h8;
    localparam logic [3:0] OpLd  = 4'h9;
    localparam logic [3:0] OpSt  = 4'hA;
    localparam logic [3:0] OpBeq = 4'hB;
    localparam logic [3:0] OpBz  = 4'hC;
    localparam logic [3:0] OpJmp = 4'hD;
    localparam logic [3:0] OpHlt = 4'hF;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [15:0]       ir_q;
    logic [DATA_W-1:0] a_q, b_q, alu_q, mdr_q;
    logic [DATA_W-1:0] regs_q [4];
    logic              taken_q;

    logic [3:0]        op;
    logic [1:0]        rd, rs;
    logic [DATA_W-1:0] imm_data;
    logic [ADDR_W-1:0] imm_addr;
    logic              is_mem, is_alu, writes_rd;
    logic [DATA_W-1:0] alu_d;
    logic              taken_d;

    assign op        = ir_q[15:12];
    assign rd        = ir_q[11:10];
    assign rs        = ir_q[9:8];
    assign imm_data  = DATA_W'(ir_q[7:0]);
    assign imm_addr  = ADDR_W'(ir_q[7:0]);
    assign is_mem    = (op == OpLd) || (op == OpSt);
    assign is_alu    = (op >= OpLdi) && (op <= OpShl);
    assign writes_rd = is_alu || (op == OpLd);

    always_comb begin
        alu_d = a_q;
        case (op)
            OpLdi:   alu_d = imm_data;
            OpAdd:   alu_d = a_q + b_q;
            OpSub:   alu_d = a_q - b_q;
            OpAnd:   alu_d = a_q & b_q;
            OpOr:    alu_d = a_q | b_q;
            OpXor:   alu_d = a_q ^ b_q;
            OpNot:   alu_d = ~b_q;
            OpShl:   alu_d = a_q << 1;
            default: alu_d = a_q;
        endcase
    end

    always_comb begin
        taken_d = 1'b0;
        case (op)
            OpBeq:   taken_d = (a_q == b_q);
            OpBz:    taken_d = (a_q == '0);
            OpJmp:   taken_d = 1'b1;
            default: taken_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StInit;
            pc_q    <= '0;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_q   <= '0;
            mdr_q   <= '0;
            taken_q <= 1'b0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            unique case (state_q)
                StInit: state_q <= StFetch;
                StFetch: begin
                    if (bus.imem_ack) begin
                        ir_q    <= bus.imem_rdata;
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    a_q     <= regs_q[rd];
                    b_q     <= regs_q[rs];
                    state_q <= StExec;
                end
                StExec: begin
                    // Only ALU/LDI ops update the visible ALU result.
                    if (is_alu) alu_q <= alu_d;
                    taken_q <= taken_d;
                    if (op == OpHlt)  state_q <= StHalt;
                    else if (is_mem)  state_q <= StMem;
                    else              state_q <= StWb;
                end
                StMem: begin
                    if (bus.dmem_ack) begin
                        if (op == OpLd) mdr_q <= bus.dmem_rdata;
                        state_q <= StWb;
                    end
                end
                StWb: begin
                    if (writes_rd) regs_q[rd] <= (op == OpLd) ? mdr_q : alu_q;
                    pc_q    <= taken_q ? imm_addr : pc_q + ADDR_W'(1);
                    state_q <= StFetch;
                end
                StHalt:  state_q <= StHalt;
                default: state_q <= StInit;
            endcase
        end
    end

    // Bus outputs depend only on the registered state, so async reset drops them at once.
    assign bus.imem_req   = (state_q == StFetch);
    assign bus.imem_addr  = pc_q;
    assign bus.dmem_req   = (state_q == StMem);
    assign bus.dmem_we    = bus.dmem_req && (op == OpSt);
    assign bus.dmem_addr  = bus.dmem_req ? imm_addr : '0;
    assign bus.dmem_wdata = bus.dmem_req ? b_q : '0;

    assign halted           = (state_q == StHalt);
    assign debug_pc         = pc_q;
    assign debug_alu_result = alu_q;
    assign debug_state      = state_q;
endmodule
